// File: rtl/ccr_pkg.sv
// Shared encodings for the condition-code register stage: flag indices, condition codes,
// update/write operation encodings and the DBcc sequencing states.
package ccr_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_X = 4;

    localparam logic [3:0] COND_T  = 4'h0;
    localparam logic [3:0] COND_F  = 4'h1;
    localparam logic [3:0] COND_HI = 4'h2;
    localparam logic [3:0] COND_LS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_CS = 4'h5;
    localparam logic [3:0] COND_NE = 4'h6;
    localparam logic [3:0] COND_EQ = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_VS = 4'h9;
    localparam logic [3:0] COND_PL = 4'hA;
    localparam logic [3:0] COND_MI = 4'hB;
    localparam logic [3:0] COND_GE = 4'hC;
    localparam logic [3:0] COND_LT = 4'hD;
    localparam logic [3:0] COND_GT = 4'hE;
    localparam logic [3:0] COND_LE = 4'hF;

    localparam logic [1:0] UPD_NORMAL  = 2'b00;
    localparam logic [1:0] UPD_XCOPY   = 2'b01;
    localparam logic [1:0] UPD_ZSTICKY = 2'b10;
    localparam logic [1:0] UPD_LOGIC   = 2'b11;

    localparam logic [1:0] WR_MOVE = 2'b00;
    localparam logic [1:0] WR_AND  = 2'b01;
    localparam logic [1:0] WR_OR   = 2'b10;
    localparam logic [1:0] WR_EOR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StEval = 2'b01,
        StDone = 2'b10
    } dbcc_state_t;

endpackage

// File: rtl/ccr_cond_eval.sv
// Combinational evaluation of the sixteen 68k condition codes against a {X,N,Z,V,C} CCR.
module ccr_cond_eval
    import ccr_pkg::*;
(
    input  logic [4:0] ccr,
    input  logic [3:0] cond,
    output logic       is_true
);

    logic n, z, v, c;
    logic unused_x;

    assign n        = ccr[FLAG_N];
    assign z        = ccr[FLAG_Z];
    assign v        = ccr[FLAG_V];
    assign c        = ccr[FLAG_C];
    assign unused_x = ccr[FLAG_X];

    always_comb begin
        is_true = 1'b0;
        unique case (cond)
            COND_T:  is_true = 1'b1;
            COND_F:  is_true = 1'b0;
            COND_HI: is_true = ~c & ~z;
            COND_LS: is_true = c | z;
            COND_CC: is_true = ~c;
            COND_CS: is_true = c;
            COND_NE: is_true = ~z;
            COND_EQ: is_true = z;
            COND_VC: is_true = ~v;
            COND_VS: is_true = v;
            COND_PL: is_true = ~n;
            COND_MI: is_true = n;
            COND_GE: is_true = ~(n ^ v);
            COND_LT: is_true = n ^ v;
            COND_GT: is_true = ~z & ~(n ^ v);
            COND_LE: is_true = z | (n ^ v);
        endcase
    end

endmodule

// File: rtl/ccr_unit.sv
// 68k CCR stage: masked Alu flag update, explicit CCR writes, condition evaluation and DBcc pipe.
// Optional shadow save/restore is built only when CCR_SAVE_EN is defined.
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_c,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic            alu_n,
    input  logic            upd_valid,
    input  logic [4:0]      upd_mask,
    input  logic [1:0]      upd_mode,
    input  logic            wr_valid,
    input  logic [1:0]      wr_op,
    input  logic [4:0]      wr_data,
    input  logic [3:0]      cond,
    output logic            cond_true,
    input  logic            dbcc_req,
    input  logic [BITS-1:0] dbcc_cnt_in,
    output logic            dbcc_busy,
    output logic            dbcc_ack,
    output logic            dbcc_branch,
    output logic [BITS-1:0] dbcc_cnt_out,
    output logic [4:0]      ccr,
    input  logic            save_req,
    input  logic            restore_req
);

    logic [4:0]      alu_flags;
    logic [4:0]      upd_next;
    logic [4:0]      wr_next;
    logic [4:0]      ccr_next;
    logic            dbcc_cond;
    logic            cap_true;
    logic [BITS-1:0] cap_cnt;
    logic [BITS-1:0] cnt_dec;
    dbcc_state_t     state;

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_X] = alu_c;
        alu_flags[FLAG_N] = alu_n;
        alu_flags[FLAG_Z] = alu_z;
        alu_flags[FLAG_V] = alu_v;
        alu_flags[FLAG_C] = alu_c;
        case (upd_mode)
            UPD_ZSTICKY: alu_flags[FLAG_Z] = ccr[FLAG_Z] & alu_z;
            UPD_LOGIC: begin
                // Logic ops never touch X, whatever the mask says.
                alu_flags[FLAG_X] = ccr[FLAG_X];
                alu_flags[FLAG_V] = 1'b0;
                alu_flags[FLAG_C] = 1'b0;
            end
            default: ;
        endcase
        upd_next = (ccr & ~upd_mask) | (alu_flags & upd_mask);

        wr_next = wr_data;
        case (wr_op)
            WR_AND:  wr_next = ccr & wr_data;
            WR_OR:   wr_next = ccr | wr_data;
            WR_EOR:  wr_next = ccr ^ wr_data;
            default: wr_next = wr_data;
        endcase
    end

`ifdef CCR_SAVE_EN
    logic [4:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (save_req) begin
            shadow <= ccr;
        end
    end

    always_comb begin
        ccr_next = ccr;
        if (restore_req) begin
            ccr_next = shadow;
        end else if (wr_valid) begin
            ccr_next = wr_next;
        end else if (upd_valid) begin
            ccr_next = upd_next;
        end
    end
`else
    logic unused_shadow_ctl;
    assign unused_shadow_ctl = save_req ^ restore_req;

    always_comb begin
        ccr_next = ccr;
        if (wr_valid) begin
            ccr_next = wr_next;
        end else if (upd_valid) begin
            ccr_next = upd_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ccr <= '0;
        end else begin
            ccr <= ccr_next;
        end
    end

    ccr_cond_eval u_cond_out (
        .ccr     (ccr),
        .cond    (cond),
        .is_true (cond_true)
    );

    ccr_cond_eval u_cond_dbcc (
        .ccr     (ccr),
        .cond    (cond),
        .is_true (dbcc_cond)
    );

    assign cnt_dec = cap_cnt - BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            cap_true     <= 1'b0;
            cap_cnt      <= '0;
            dbcc_busy    <= 1'b0;
            dbcc_ack     <= 1'b0;
            dbcc_branch  <= 1'b0;
            dbcc_cnt_out <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (dbcc_req) begin
                        cap_true  <= dbcc_cond;
                        cap_cnt   <= dbcc_cnt_in;
                        dbcc_busy <= 1'b1;
                        state     <= StEval;
                    end
                end
                StEval: begin
                    if (cap_true) begin
                        dbcc_branch  <= 1'b0;
                        dbcc_cnt_out <= cap_cnt;
                    end else begin
                        // Falling out of the loop when the counter wraps to -1.
                        dbcc_branch  <= (cnt_dec != '1);
                        dbcc_cnt_out <= cnt_dec;
                    end
                    dbcc_ack <= 1'b1;
                    state    <= StDone;
                end
                StDone: begin
                    dbcc_ack  <= 1'b0;
                    dbcc_busy <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit; shadow save/restore scenarios need CCR_SAVE_EN.
module tb_ccr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_c, alu_z, alu_v, alu_n;
    logic        upd_valid;
    logic [4:0]  upd_mask;
    logic [1:0]  upd_mode;
    logic        wr_valid;
    logic [1:0]  wr_op;
    logic [4:0]  wr_data;
    logic [3:0]  cond;
    logic        cond_true;
    logic        dbcc_req;
    logic [15:0] dbcc_cnt_in;
    logic        dbcc_busy, dbcc_ack, dbcc_branch;
    logic [15:0] dbcc_cnt_out;
    logic [4:0]  ccr;
    logic        save_req, restore_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccr_unit #(.BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_v        (alu_v),
        .alu_n        (alu_n),
        .upd_valid    (upd_valid),
        .upd_mask     (upd_mask),
        .upd_mode     (upd_mode),
        .wr_valid     (wr_valid),
        .wr_op        (wr_op),
        .wr_data      (wr_data),
        .cond         (cond),
        .cond_true    (cond_true),
        .dbcc_req     (dbcc_req),
        .dbcc_cnt_in  (dbcc_cnt_in),
        .dbcc_busy    (dbcc_busy),
        .dbcc_ack     (dbcc_ack),
        .dbcc_branch  (dbcc_branch),
        .dbcc_cnt_out (dbcc_cnt_out),
        .ccr          (ccr),
        .save_req     (save_req),
        .restore_req  (restore_req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [4:0] data);
        wr_valid = 1'b1;
        wr_op    = op;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_update(input logic [1:0] mode, input logic [4:0] mask,
                             input logic n, input logic z, input logic v, input logic c);
        upd_valid = 1'b1;
        upd_mode  = mode;
        upd_mask  = mask;
        {alu_n, alu_z, alu_v, alu_c} = {n, z, v, c};
        tick();
        upd_valid = 1'b0;
    endtask

    // Independent reference for the condition table, phrased per code.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] nzvc);
        logic n, z, v, c;
        {n, z, v, c} = nzvc;
        case (cc)
            4'h0: return 1'b1;
            4'h1: return 1'b0;
            4'h2: return (c == 1'b0) && (z == 1'b0);
            4'h3: return (c == 1'b1) || (z == 1'b1);
            4'h4: return c == 1'b0;
            4'h5: return c == 1'b1;
            4'h6: return z == 1'b0;
            4'h7: return z == 1'b1;
            4'h8: return v == 1'b0;
            4'h9: return v == 1'b1;
            4'hA: return n == 1'b0;
            4'hB: return n == 1'b1;
            4'hC: return n == v;
            4'hD: return n != v;
            4'hE: return (z == 1'b0) && (n == v);
            default: return (z == 1'b1) || (n != v);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (ccr !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ccr got %b want %b", ccr, 5'b00000);
        end
        checks++;
        if ({dbcc_busy, dbcc_ack, dbcc_branch} !== 3'b000) begin
            errors++;
            $display("FAIL reset_dbcc_flags got %b want 000", {dbcc_busy, dbcc_ack, dbcc_branch});
        end
        checks++;
        if (dbcc_cnt_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt_out got %h want 0000", dbcc_cnt_out);
        end
    endtask

    task automatic test_normal();
        do_update(2'b00, 5'h1F, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ccr !== 5'b11011) begin
            errors++;
            $display("FAIL normal_all got %b want %b", ccr, 5'b11011);
        end
        // Only C enabled: C clears, rest untouched.
        do_update(2'b00, 5'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ccr !== 5'b11010) begin
            errors++;
            $display("FAIL normal_masked got %b want %b", ccr, 5'b11010);
        end
        do_write(2'b00, 5'b00000);
        do_update(2'b01, 5'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ccr !== 5'b10000) begin
            errors++;
            $display("FAIL xcopy_x got %b want %b", ccr, 5'b10000);
        end
    endtask

    task automatic test_zsticky();
        logic [4:0] exp_seq [3];
        logic       z_seq   [3];
        exp_seq = '{5'b00100, 5'b00000, 5'b00000};
        z_seq   = '{1'b1, 1'b0, 1'b1};
        do_write(2'b00, 5'b00100);
        for (int i = 0; i < 3; i++) begin
            do_update(2'b10, 5'h04, 1'b0, z_seq[i], 1'b0, 1'b0);
            checks++;
            if (ccr !== exp_seq[i]) begin
                errors++;
                $display("FAIL zsticky_step%0d got %b want %b", i, ccr, exp_seq[i]);
            end
        end
    endtask

    task automatic test_logic_writes();
        do_write(2'b00, 5'b11111);
        do_update(2'b11, 5'h1F, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (ccr !== 5'b10100) begin
            errors++;
            $display("FAIL logic_update got %b want %b", ccr, 5'b10100);
        end
        do_write(2'b11, 5'h1F);
        checks++;
        if (ccr !== 5'b01011) begin
            errors++;
            $display("FAIL eor_write got %b want %b", ccr, 5'b01011);
        end
        do_write(2'b01, 5'b00011);
        checks++;
        if (ccr !== 5'b00011) begin
            errors++;
            $display("FAIL and_write got %b want %b", ccr, 5'b00011);
        end
        do_write(2'b10, 5'b10000);
        checks++;
        if (ccr !== 5'b10011) begin
            errors++;
            $display("FAIL or_write got %b want %b", ccr, 5'b10011);
        end
    endtask

    task automatic test_priority();
        wr_valid  = 1'b1;
        wr_op     = 2'b00;
        wr_data   = 5'h00;
        upd_valid = 1'b1;
        upd_mode  = 2'b00;
        upd_mask  = 5'h1F;
        {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
        tick();
        wr_valid  = 1'b0;
        upd_valid = 1'b0;
        checks++;
        if (ccr !== 5'b00000) begin
            errors++;
            $display("FAIL wr_beats_upd got %b want %b", ccr, 5'b00000);
        end
    endtask

    task automatic test_cond_table();
        int bad = 0;
        for (int f = 0; f < 16; f++) begin
            do_write(2'b00, {1'b0, 4'(f)});
            for (int k = 0; k < 16; k++) begin
                cond = 4'(k);
                #1;
                checks++;
                if (cond_true !== ref_cond(4'(k), 4'(f))) begin
                    errors++;
                    bad++;
                    if (bad < 8)
                        $display("FAIL cond_%0h_nzvc_%b got %b want %b", k, 4'(f), cond_true,
                                 ref_cond(4'(k), 4'(f)));
                end
            end
        end
    endtask

    task automatic test_dbcc();
        logic [3:0]  v_cond   [4];
        logic [15:0] v_cnt    [4];
        logic        v_branch [4];
        logic [15:0] v_out    [4];
        v_cond   = '{4'h1, 4'h1, 4'h0, 4'h7};
        v_cnt    = '{16'd3, 16'd0, 16'd5, 16'd1};
        v_branch = '{1'b1, 1'b0, 1'b0, 1'b1};
        v_out    = '{16'd2, 16'hFFFF, 16'd5, 16'd0};
        do_write(2'b00, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            dbcc_req    = 1'b1;
            cond        = v_cond[i];
            dbcc_cnt_in = v_cnt[i];
            // Last vector: same-cycle MOVE sets Z, but EQ must see the old Z=0.
            if (i == 3) begin
                wr_valid = 1'b1;
                wr_op    = 2'b00;
                wr_data  = 5'b00100;
            end
            tick();
            wr_valid = 1'b0;
            dbcc_req = (i == 0);
            dbcc_cnt_in = 16'd9;
            checks++;
            if ({dbcc_busy, dbcc_ack} !== 2'b10) begin
                errors++;
                $display("FAIL dbcc%0d_t1 busy/ack got %b want 10", i, {dbcc_busy, dbcc_ack});
            end
            tick();
            dbcc_req = 1'b0;
            checks++;
            if ({dbcc_ack, dbcc_branch, dbcc_cnt_out} !== {1'b1, v_branch[i], v_out[i]}) begin
                errors++;
                $display("FAIL dbcc%0d_ack ack/branch/cnt got %b/%b/%h want 1/%b/%h", i,
                         dbcc_ack, dbcc_branch, dbcc_cnt_out, v_branch[i], v_out[i]);
            end
            tick();
            checks++;
            if ({dbcc_busy, dbcc_ack, dbcc_branch, dbcc_cnt_out}
                    !== {2'b00, v_branch[i], v_out[i]}) begin
                errors++;
                $display("FAIL dbcc%0d_t3 busy/ack/branch/cnt got %b/%b/%b/%h want 0/0/%b/%h",
                         i, dbcc_busy, dbcc_ack, dbcc_branch, dbcc_cnt_out, v_branch[i],
                         v_out[i]);
            end
        end
        // The ignored second request of vector 0 must not produce a later ack.
        tick();
        checks++;
        if ({dbcc_busy, dbcc_ack} !== 2'b00) begin
            errors++;
            $display("FAIL dbcc_idle_after got %b want 00", {dbcc_busy, dbcc_ack});
        end
    endtask

    task automatic test_reset_mid_dbcc();
        logic seen_ack = 1'b0;
        dbcc_req    = 1'b1;
        cond        = 4'h1;
        dbcc_cnt_in = 16'd7;
        tick();
        dbcc_req = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({dbcc_busy, dbcc_ack} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_busy got %b want 00", {dbcc_busy, dbcc_ack});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dbcc_ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_ack got %b want 0", seen_ack);
        end
    endtask

    task automatic test_shadow();
`ifdef CCR_SAVE_EN
        do_write(2'b00, 5'b01101);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        do_write(2'b00, 5'b00000);
        // Restore must win over a same-cycle write.
        restore_req = 1'b1;
        wr_valid    = 1'b1;
        wr_op       = 2'b00;
        wr_data     = 5'b11111;
        tick();
        restore_req = 1'b0;
        wr_valid    = 1'b0;
        checks++;
        if (ccr !== 5'b01101) begin
            errors++;
            $display("FAIL shadow_restore got %b want %b", ccr, 5'b01101);
        end
        do_write(2'b00, 5'b10010);
        save_req    = 1'b1;
        restore_req = 1'b1;
        tick();
        save_req    = 1'b0;
        restore_req = 1'b0;
        checks++;
        if (ccr !== 5'b01101) begin
            errors++;
            $display("FAIL shadow_swap_ccr got %b want %b", ccr, 5'b01101);
        end
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        checks++;
        if (ccr !== 5'b10010) begin
            errors++;
            $display("FAIL shadow_swap_old got %b want %b", ccr, 5'b10010);
        end
`else
        do_write(2'b00, 5'b01101);
        save_req = 1'b1;
        tick();
        save_req    = 1'b0;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        checks++;
        if (ccr !== 5'b01101) begin
            errors++;
            $display("FAIL restore_ignored got %b want %b", ccr, 5'b01101);
        end
`endif
    endtask

    initial begin
        reset       = 1'b1;
        {alu_c, alu_z, alu_v, alu_n} = 4'b0000;
        upd_valid   = 1'b0;
        upd_mask    = 5'h00;
        upd_mode    = 2'b00;
        wr_valid    = 1'b0;
        wr_op       = 2'b00;
        wr_data     = 5'h00;
        cond        = 4'h0;
        dbcc_req    = 1'b0;
        dbcc_cnt_in = 16'h0000;
        save_req    = 1'b0;
        restore_req = 1'b0;

        test_reset();
        test_normal();
        test_zsticky();
        test_logic_writes();
        test_priority();
        test_cond_table();
        test_dbcc();
        test_reset_mid_dbcc();
        test_shadow();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
